// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset constants, opcodes and fetch FSM encoding.
// Opcode constants are also used by the main decoder.
package instr_fetch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, decode-side handshake and status.
// master = fetch unit, slave = memory/datapath side.
interface instr_fetch_unit_if #(parameter int XLEN = 32);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [6:0]      op;
    logic [XLEN-1:0] instr_pc;
    logic            fetch_fault;
    logic [31:0]     retire_cnt;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  pc_src, pc_target, instr_ready,
        output instr_valid, instr, op, instr_pc, fetch_fault, retire_cnt
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output pc_src, pc_target, instr_ready,
        input  instr_valid, instr, op, instr_pc, fetch_fault, retire_cnt
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_reg.sv
// PC register with +4 increment, redirect mux and misaligned-target detection.
module instr_fetch_unit_pc_next_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            consume,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q;

    assign misaligned = pc_src && is_misaligned(pc_target[1:0]);
    assign pc         = pc_q;

    // A misaligned redirect leaves the PC where it was; the FSM parks in fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (consume && !misaligned) begin
            pc_q <= pc_src ? pc_target : pc_q + XLEN'(4);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: requests words from instruction memory and holds them for the decoder.
//
//   state   | meaning
//   S_REQ   | request pc from memory (after first post-reset edge)
//   S_WAIT  | request accepted, waiting for response word
//   S_HOLD  | instruction valid, waiting for datapath to consume
//   S_FAULT | misaligned redirect seen, idle until reset
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic            armed_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            fault_q;
    logic [31:0]     retire_q;
    logic [XLEN-1:0] pc;
    logic            misaligned;
    logic            consume;
    logic            req_valid;
    logic            instr_valid;

    assign consume = (state_q == S_HOLD) && bus.instr_ready;

    instr_fetch_unit_pc_next_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_next_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .consume    (consume),
        .pc_src     (bus.pc_src),
        .pc_target  (bus.pc_target),
        .pc         (pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        req_valid   = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_REQ: begin
                req_valid = armed_q;
                if (armed_q && bus.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) state_d = S_HOLD;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (bus.instr_ready) state_d = misaligned ? S_FAULT : S_REQ;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // armed_q keeps the request low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            retire_q   <= '0;
        end else begin
            if ((state_q == S_WAIT) && bus.imem_rsp_valid) begin
                instr_q    <= bus.imem_rsp_data;
                instr_pc_q <= pc;
            end
            if (consume) begin
                retire_q <= retire_q + 32'd1;
                if (misaligned) fault_q <= 1'b1;
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc;
    assign bus.instr_valid    = instr_valid;
    assign bus.instr          = instr_q;
    assign bus.op             = instr_q[6:0];
    assign bus.instr_pc       = instr_pc_q;
    assign bus.fetch_fault    = fault_q;
    assign bus.retire_cnt     = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency memory responder.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc_no = 0;
    int          last_v = 0;
    logic        mem_auto;
    logic        acc;
    logic [31:0] acc_addr;
    logic [31:0] w;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = OP_R;
            2'd1:    opc = OP_I;
            2'd2:    opc = OP_L;
            default: opc = OP_B;
        endcase
        return {a[26:2], opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory samples the handshake before the edge and answers in the next cycle.
    task automatic cyc();
        acc      = mem_auto && bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = acc;
        bus.imem_rsp_data  = acc ? mem_word(acc_addr) : 32'h0;
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, 32'(bus.imem_req_valid), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.instr_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, 32'(bus.instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        mem_auto           = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.pc_src         = 1'b0;
        bus.pc_target      = 32'h0;
        bus.instr_ready    = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr",       bus.instr, NOP_INSTR);
        chk("rst_instr_pc",    bus.instr_pc, 32'h0);
        chk("rst_addr",        bus.imem_addr, 32'h0);
        chk("rst_fault",       32'(bus.fetch_fault), 32'd0);
        chk("rst_retire",      bus.retire_cnt, 32'd0);

        // 1: zero-wait memory, continuous consume
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        rst_n              = 1'b1;
        cyc();
        chk("t1_req_first_edge", 32'(bus.imem_req_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_req("t1_req");
            chk("t1_addr", bus.imem_addr, 32'(4 * k));
            wait_valid("t1_valid");
            w = mem_word(32'(4 * k));
            chk("t1_instr",    bus.instr, w);
            chk("t1_op",       32'(bus.op), 32'(w[6:0]));
            chk("t1_instr_pc", bus.instr_pc, 32'(4 * k));
            if (k > 0) chk("t1_period", 32'(cyc_no - last_v), 32'd3);
            last_v = cyc_no;
            cyc();
        end
        chk("t1_retire", bus.retire_cnt, 32'd3);

        // 2: request and consume backpressure
        wait_valid("t2_pre");
        chk("t2_pre_pc", bus.instr_pc, 32'hC);
        bus.imem_req_ready = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr_hold", bus.imem_addr, 32'h10);
            chk("t2_req_hold",  32'(bus.imem_req_valid), 32'd1);
            cyc();
        end
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        wait_valid("t2_valid");
        w = mem_word(32'h10);
        for (int i = 0; i < 5; i++) begin
            chk("t2_instr_stable",    bus.instr, w);
            chk("t2_op_stable",       32'(bus.op), 32'(w[6:0]));
            chk("t2_instr_pc_stable", bus.instr_pc, 32'h10);
            chk("t2_valid_stable",    32'(bus.instr_valid), 32'd1);
            chk("t2_retire_stable",   bus.retire_cnt, 32'd4);
            cyc();
        end

        // 3: redirect then sequential
        bus.pc_src      = 1'b1;
        bus.pc_target   = 32'h0000_0100;
        bus.instr_ready = 1'b1;
        cyc();
        chk("t3_redirect_addr", bus.imem_addr, 32'h100);
        chk("t3_redirect_req",  32'(bus.imem_req_valid), 32'd1);
        bus.pc_src    = 1'b0;
        bus.pc_target = 32'h0;
        wait_valid("t3_valid");
        chk("t3_instr_pc", bus.instr_pc, 32'h100);
        chk("t3_instr",    bus.instr, mem_word(32'h100));
        cyc();
        chk("t3_seq_addr", bus.imem_addr, 32'h104);
        chk("t3_retire",   bus.retire_cnt, 32'd6);

        // 5: wrap of pc+4 and spurious response in S_REQ
        wait_valid("t5_pre");
        bus.pc_src    = 1'b1;
        bus.pc_target = 32'hFFFF_FFFC;
        cyc();
        chk("t5_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.pc_src    = 1'b0;
        bus.pc_target = 32'h0;
        wait_valid("t5_top_valid");
        chk("t5_top_pc", bus.instr_pc, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b0;
        cyc();
        chk("t5_wrap_addr", bus.imem_addr, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        chk("t5_spurious_instr", bus.instr, mem_word(32'hFFFF_FFFC));
        chk("t5_spurious_valid", 32'(bus.instr_valid), 32'd0);
        chk("t5_spurious_req",   32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        wait_valid("t5_wrap_valid");
        chk("t5_wrap_instr", bus.instr, mem_word(32'h0));
        chk("t5_wrap_pc",    bus.instr_pc, 32'h0);

        // 4: misaligned redirect
        bus.pc_src    = 1'b1;
        bus.pc_target = 32'h0000_0102;
        cyc();
        bus.pc_src    = 1'b0;
        bus.pc_target = 32'h0;
        chk("t4_fault",  32'(bus.fetch_fault), 32'd1);
        chk("t4_retire", bus.retire_cnt, 32'd9);
        chk("t4_pc_kept", bus.imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("t4_valids_low", {30'd0, bus.imem_req_valid, bus.instr_valid}, 32'd0);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("t4_rst_fault",  32'(bus.fetch_fault), 32'd0);
        chk("t4_rst_retire", bus.retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        wait_req("t4_restart");
        chk("t4_restart_addr", bus.imem_addr, 32'h0);

        // 6: async reset while waiting for a response
        wait_valid("t6_pre");
        cyc();
        chk("t6_pre_retire", bus.retire_cnt, 32'd1);
        mem_auto = 1'b0;
        cyc();
        chk("t6_in_wait_req", 32'(bus.imem_req_valid), 32'd0);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_retire",   bus.retire_cnt, 32'd0);
        chk("t6_async_addr",     bus.imem_addr, 32'h0);
        chk("t6_async_instr",    bus.instr, NOP_INSTR);
        chk("t6_async_instr_pc", bus.instr_pc, 32'h0);
        chk("t6_async_req",      32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n              = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        mem_auto           = 1'b1;
        cyc();
        chk("t6_late_rsp_dropped", bus.instr, NOP_INSTR);
        chk("t6_first_req",        32'(bus.imem_req_valid), 32'd1);
        chk("t6_first_addr",       bus.imem_addr, 32'h0);
        wait_valid("t6_valid");
        chk("t6_instr", bus.instr, mem_word(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
